// File: rtl/instr_boot_loader.sv
// Boot-time loader: holds the core in reset, pulls the program from the instruction
// transmitter and writes it word by word into instruction memory, then releases the core.
module instr_boot_loader #(
    parameter int IWIDTH  = 32,
    parameter int DEPTH   = 64,
    parameter int AWIDTH  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              bl_clk,
    input  logic              bl_rst,
    input  logic              bl_i_start,
    output logic              bl_o_syn,
    input  logic [IWIDTH-1:0] bl_i_instr,
    input  logic              bl_i_ack,
    input  logic              bl_i_last,
    output logic              bl_o_we,
    output logic [AWIDTH-1:0] bl_o_waddr,
    output logic [IWIDTH-1:0] bl_o_wdata,
    output logic              bl_o_core_rst,
    output logic              bl_o_busy,
    output logic              bl_o_done,
    output logic              bl_o_err,
    output logic [AWIDTH:0]   bl_o_count
);

    localparam int TWIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH:0]   MAX_COUNT = (AWIDTH + 1)'(DEPTH);
    localparam logic [TWIDTH-1:0] TIMER_MAX = TWIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              state;
    logic [AWIDTH-1:0]   waddr_q;
    logic [AWIDTH:0]     count_q;
    logic [TWIDTH-1:0]   timer_q;
    logic                we_q;
    logic [AWIDTH-1:0]   waddr_out_q;
    logic [IWIDTH-1:0]   wdata_q;
    logic                core_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    // Sync drops in the same cycle the last word is presented so the transmitter
    // never advances past the end of the program.
    assign bl_o_syn = (state == ST_LOAD) & ~(bl_i_ack & bl_i_last);

    always_ff @(posedge bl_clk or negedge bl_rst) begin
        if (!bl_rst) begin
            state       <= ST_IDLE;
            waddr_q     <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            we_q        <= 1'b0;
            waddr_out_q <= '0;
            wdata_q     <= '0;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (bl_i_start && (state != ST_LOAD)) begin
                state      <= ST_LOAD;
                waddr_q    <= '0;
                count_q    <= '0;
                timer_q    <= '0;
                core_rst_q <= 1'b0;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (bl_i_ack) begin
                            we_q        <= 1'b1;
                            waddr_out_q <= waddr_q;
                            wdata_q     <= bl_i_instr;
                            timer_q     <= '0;
                            if (count_q != MAX_COUNT) begin
                                count_q <= count_q + 1'b1;
                            end
                            // Ack beats timeout; last beats overflow.
                            if (bl_i_last) begin
                                state  <= ST_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else if (waddr_q == LAST_ADDR) begin
                                state  <= ST_ERR;
                                busy_q <= 1'b0;
                                err_q  <= 1'b1;
                            end else begin
                                waddr_q <= waddr_q + 1'b1;
                            end
                        end else if (timer_q == TIMER_MAX) begin
                            state  <= ST_ERR;
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        core_rst_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bl_o_we       = we_q;
    assign bl_o_waddr    = waddr_out_q;
    assign bl_o_wdata    = wdata_q;
    assign bl_o_core_rst = core_rst_q;
    assign bl_o_busy     = busy_q;
    assign bl_o_done     = done_q;
    assign bl_o_err      = err_q;
    assign bl_o_count    = count_q;

endmodule

// File: tb/tb_instr_boot_loader.sv
// Bench for instr_boot_loader: a default-size instance for load/timeout/reset scenarios
// and a DEPTH=4 instance for the overflow case, both checked against a write-list model.
module tb_instr_boot_loader;

    localparam int IW      = 32;
    localparam int DEPTH   = 64;
    localparam int AW      = 6;
    localparam int TO      = 16;
    localparam int S_DEPTH = 4;
    localparam int S_AW    = 2;
    // scoreboard entry: {write cycle, address, data, sync seen in the ack cycle}
    localparam int W       = 73;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start, ack, last;
    logic [IW-1:0] instr;
    logic          syn, we, core_rst, busy, done, err;
    logic [AW-1:0] waddr;
    logic [IW-1:0] wdata;
    logic [AW:0]   count;

    logic            s_start, s_ack, s_last;
    logic [IW-1:0]   s_instr;
    logic            s_syn, s_we, s_core_rst, s_busy, s_done, s_err;
    logic [S_AW-1:0] s_waddr;
    logic [IW-1:0]   s_wdata;
    logic [S_AW:0]   s_count;

    instr_boot_loader #(.IWIDTH(IW), .DEPTH(DEPTH), .AWIDTH(AW), .TIMEOUT(TO)) dut (
        .bl_clk(clk), .bl_rst(rst_n), .bl_i_start(start), .bl_o_syn(syn),
        .bl_i_instr(instr), .bl_i_ack(ack), .bl_i_last(last), .bl_o_we(we),
        .bl_o_waddr(waddr), .bl_o_wdata(wdata), .bl_o_core_rst(core_rst),
        .bl_o_busy(busy), .bl_o_done(done), .bl_o_err(err), .bl_o_count(count)
    );

    instr_boot_loader #(.IWIDTH(IW), .DEPTH(S_DEPTH), .AWIDTH(S_AW), .TIMEOUT(TO)) dut_small (
        .bl_clk(clk), .bl_rst(rst_n), .bl_i_start(s_start), .bl_o_syn(s_syn),
        .bl_i_instr(s_instr), .bl_i_ack(s_ack), .bl_i_last(s_last), .bl_o_we(s_we),
        .bl_o_waddr(s_waddr), .bl_o_wdata(s_wdata), .bl_o_core_rst(s_core_rst),
        .bl_o_busy(s_busy), .bl_o_done(s_done), .bl_o_err(s_err), .bl_o_count(s_count)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    logic [W-1:0] s_exp_q[$];
    logic [W-1:0] s_act_q[$];
    logic syn_prev = 1'b0;
    logic s_syn_prev = 1'b0;

    // Instruction-memory side monitor: every write cycle becomes one scoreboard entry.
    always @(negedge clk) begin
        if (we === 1'b1) act_q.push_back({32'(cyc), 8'(waddr), wdata, syn_prev});
        if (s_we === 1'b1) s_act_q.push_back({32'(cyc), 8'(s_waddr), s_wdata, s_syn_prev});
        syn_prev   <= syn;
        s_syn_prev <= s_syn;
    end

    logic [IW-1:0] stim_word[DEPTH];
    int            stim_gap[DEPTH];

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // Word i of a load lands at address i one cycle after its ack; sync is low only
    // in the ack cycle that carries last.
    task automatic drive_stream(input int n, input bit use_last, input bit poke_start);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < stim_gap[i]; k++) begin
                @(posedge clk); #1;
            end
            ack   = 1'b1;
            instr = stim_word[i];
            last  = use_last && (i == n - 1);
            start = poke_start && (i == 1);
            exp_q.push_back({32'(cyc + 1), 8'(i), stim_word[i], ~last});
            @(posedge clk); #1;
            ack = 1'b0; last = 1'b0; start = 1'b0; instr = '0;
        end
    endtask

    task automatic fill_random(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            stim_word[i] = $urandom();
            stim_gap[i]  = (max_gap > 0) ? $urandom_range(max_gap, 1) : 0;
        end
    endtask

    task automatic fill_program();
        stim_word[0] = 32'h20080005; stim_word[1] = 32'h20090003;
        stim_word[2] = 32'h01095020; stim_word[3] = 32'hAC0A0000;
        for (int i = 0; i < 4; i++) stim_gap[i] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; ack = 0; last = 0; instr = '0;
        s_start = 0; s_ack = 0; s_last = 0; s_instr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({we, core_rst, busy, done, err, syn} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {we, core_rst, busy, done, err, syn});
        else pass_cnt++;
        total_cnt++;
        if (waddr !== '0 || count !== '0 || wdata !== '0)
            $display("FAIL reset_regs: got waddr=%0d count=%0d wdata=%h want 0", waddr, count, wdata);
        else pass_cnt++;
        total_cnt++;
        if ({s_we, s_core_rst, s_busy, s_done, s_err, s_syn} !== 6'b0)
            $display("FAIL reset_small: got %b want 000000", {s_we, s_core_rst, s_busy, s_done, s_err, s_syn});
        else pass_cnt++;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_basic_load();
        logic [W-1:0] e, a;
        fill_program();
        pulse_start();
        total_cnt++;
        if (busy !== 1'b1 || core_rst !== 1'b0)
            $display("FAIL basic_enter: got busy=%b core_rst=%b want 1 0", busy, core_rst);
        else pass_cnt++;
        drive_stream(4, 1'b1, 1'b0);
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b0 || count !== 7'd4)
            $display("FAIL basic_final_write: got done=%b busy=%b core_rst=%b count=%0d want 1 0 0 4",
                     done, busy, core_rst, count);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (core_rst !== 1'b1 || done !== 1'b1 || syn !== 1'b0 || we !== 1'b0 || count !== 7'd4)
            $display("FAIL basic_done: got core_rst=%b done=%b syn=%b we=%b count=%0d want 1 1 0 0 4",
                     core_rst, done, syn, we, count);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() != exp_q.size())
            $display("FAIL basic_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            total_cnt++;
            if (a !== e) $display("FAIL basic_write: got %h want %h", a, e);
            else pass_cnt++;
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_timeout();
        logic [W-1:0] e, a;
        pulse_start();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            total_cnt++;
            if (busy !== 1'b1 || err !== 1'b0 || syn !== 1'b1)
                $display("FAIL timeout_wait: cycle %0d got busy=%b err=%b syn=%b want 1 0 1", i, busy, err, syn);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (err !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b0 || done !== 1'b0)
            $display("FAIL timeout_err: got err=%b busy=%b core_rst=%b done=%b want 1 0 0 0",
                     err, busy, core_rst, done);
        else pass_cnt++;
        ack = 1'b1; last = 1'b1; instr = $urandom();
        @(posedge clk); #1; ack = 1'b0; last = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (err !== 1'b1 || act_q.size() != 0)
            $display("FAIL timeout_ack_in_err: got err=%b writes=%0d want 1 0", err, act_q.size());
        else pass_cnt++;
        fill_random(5, 0);
        pulse_start();
        total_cnt++;
        if (err !== 1'b0 || busy !== 1'b1 || count !== '0)
            $display("FAIL retry_enter: got err=%b busy=%b count=%0d want 0 1 0", err, busy, count);
        else pass_cnt++;
        drive_stream(5, 1'b1, 1'b0);
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b1 || core_rst !== 1'b1 || count !== 7'd5)
            $display("FAIL retry_done: got done=%b core_rst=%b count=%0d want 1 1 5", done, core_rst, count);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() != exp_q.size())
            $display("FAIL retry_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            total_cnt++;
            if (a !== e) $display("FAIL retry_write: got %h want %h", a, e);
            else pass_cnt++;
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_timeout_edge();
        logic [W-1:0] e, a;
        stim_word[0] = $urandom();
        stim_gap[0]  = TO - 1;
        pulse_start();
        drive_stream(1, 1'b1, 1'b0);
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b1 || err !== 1'b0 || count !== 7'd1 || core_rst !== 1'b1)
            $display("FAIL edge_done: got done=%b err=%b count=%0d core_rst=%b want 1 0 1 1",
                     done, err, count, core_rst);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() != exp_q.size())
            $display("FAIL edge_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            total_cnt++;
            if (a !== e) $display("FAIL edge_write: got %h want %h", a, e);
            else pass_cnt++;
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_bubbles();
        logic [W-1:0] e, a;
        fill_random(8, 3);
        pulse_start();
        drive_stream(8, 1'b1, 1'b1);
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b1 || err !== 1'b0 || count !== 7'd8)
            $display("FAIL bubbles_done: got done=%b err=%b count=%0d want 1 0 8", done, err, count);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() != exp_q.size())
            $display("FAIL bubbles_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            total_cnt++;
            if (a !== e) $display("FAIL bubbles_write: got %h want %h", a, e);
            else pass_cnt++;
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_reset_mid_load();
        logic [W-1:0] e, a;
        fill_random(4, 0);
        pulse_start();
        drive_stream(2, 1'b0, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({we, busy, done, err, core_rst, syn} !== 6'b0 || count !== '0 || waddr !== '0 || wdata !== '0)
            $display("FAIL midreset_outputs: got flags=%b count=%0d waddr=%0d wdata=%h want 0",
                     {we, busy, done, err, core_rst, syn}, count, waddr, wdata);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() != exp_q.size())
            $display("FAIL midreset_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        exp_q.delete(); act_q.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        fill_random(4, 2);
        pulse_start();
        drive_stream(4, 1'b1, 1'b0);
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b1 || count !== 7'd4 || core_rst !== 1'b1)
            $display("FAIL midreset_reload: got done=%b count=%0d core_rst=%b want 1 4 1", done, count, core_rst);
        else pass_cnt++;
        total_cnt++;
        if (act_q.size() != exp_q.size())
            $display("FAIL midreset_reload_nwrites: got %0d want %0d", act_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            total_cnt++;
            if (a !== e) $display("FAIL midreset_write: got %h want %h", a, e);
            else pass_cnt++;
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, a;
        fill_program();
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            total_cnt++;
            if (core_rst !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || count !== '0)
                $display("FAIL b2b_enter: pass %0d got core_rst=%b busy=%b done=%b count=%0d want 0 1 0 0",
                         pass, core_rst, busy, done, count);
            else pass_cnt++;
            drive_stream(4, 1'b1, 1'b0);
            @(posedge clk); #1;
            total_cnt++;
            if (done !== 1'b1 || core_rst !== 1'b1 || count !== 7'd4)
                $display("FAIL b2b_done: pass %0d got done=%b core_rst=%b count=%0d want 1 1 4",
                         pass, done, core_rst, count);
            else pass_cnt++;
            total_cnt++;
            if (act_q.size() != exp_q.size())
                $display("FAIL b2b_nwrites: pass %0d got %0d want %0d", pass, act_q.size(), exp_q.size());
            else pass_cnt++;
            while (exp_q.size() > 0 && act_q.size() > 0) begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                total_cnt++;
                if (a !== e) $display("FAIL b2b_write: pass %0d got %h want %h", pass, a, e);
                else pass_cnt++;
            end
            exp_q.delete(); act_q.delete();
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] e, a;
        logic [IW-1:0] word;
        @(posedge clk); #1; s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        // One more ack than the memory holds; only DEPTH words may be written.
        for (int i = 0; i <= S_DEPTH; i++) begin
            word = $urandom();
            s_ack = 1'b1; s_instr = word; s_last = 1'b0;
            if (i < S_DEPTH) s_exp_q.push_back({32'(cyc + 1), 8'(i), word, 1'b1});
            @(posedge clk); #1;
            s_ack = 1'b0; s_instr = '0;
        end
        total_cnt++;
        if (s_err !== 1'b1 || s_busy !== 1'b0 || s_core_rst !== 1'b0 || s_done !== 1'b0 || s_we !== 1'b0)
            $display("FAIL overflow_state: got err=%b busy=%b core_rst=%b done=%b we=%b want 1 0 0 0 0",
                     s_err, s_busy, s_core_rst, s_done, s_we);
        else pass_cnt++;
        total_cnt++;
        if (s_count !== 3'd4)
            $display("FAIL overflow_count: got %0d want 4", s_count);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (s_act_q.size() != s_exp_q.size())
            $display("FAIL overflow_nwrites: got %0d want %0d", s_act_q.size(), s_exp_q.size());
        else pass_cnt++;
        while (s_exp_q.size() > 0 && s_act_q.size() > 0) begin
            e = s_exp_q.pop_front(); a = s_act_q.pop_front();
            total_cnt++;
            if (a !== e) $display("FAIL overflow_write: got %h want %h", a, e);
            else pass_cnt++;
        end
        s_exp_q.delete(); s_act_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_load();
        test_timeout();
        test_timeout_edge();
        test_bubbles();
        test_reset_mid_load();
        test_back_to_back();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
